// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1024;

    localparam int P_CPU = 0;
    localparam int P_DBG = 1;

    typedef enum logic {
        ST_CLEAR,
        ST_SERVE
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request, grant and read return.
interface dmem_port_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After a grant the pointer moves to the port that lost (or did not ask).
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (|gnt) begin
            rr_ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU and loader ports, and zeroes
// the whole memory with a hardware walk after reset or on clear_req.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | writing zero to address clr_cnt, no grants, busy high
//   ST_SERVE | round-robin arbitration of the two ports, one access/cycle
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    dmem_port_if.slave        p0,
    dmem_port_if.slave        p1,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  clr_cnt;
    logic [CNT_W-1:0]  clr_cnt_nxt;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              arb_en;
    logic              rd_pend;
    logic              rd_port;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign req    = {p1.req, p0.req};
    assign arb_en = (state == ST_SERVE) && !reset;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign p0.gnt = gnt[P_CPU];
    assign p1.gnt = gnt[P_DBG];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        case (state)
            ST_CLEAR: begin
                busy        = 1'b1;
                mem_wen     = 1'b1;
                mem_addr    = clr_cnt[ADDR_W-1:0];
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = ST_SERVE;
                    clr_cnt_nxt = '0;
                end
            end
            ST_SERVE: begin
                if (gnt[P_CPU]) begin
                    mem_wen  = p0.we;
                    mem_ren  = !p0.we;
                    mem_addr = p0.addr;
                    mem_din  = p0.we ? p0.wdata : '0;
                end else if (gnt[P_DBG]) begin
                    mem_wen  = p1.we;
                    mem_ren  = !p1.we;
                    mem_addr = p1.addr;
                    mem_din  = p1.we ? p1.wdata : '0;
                end
                // The grant above is still carried out in the clear_req cycle.
                if (clear_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
        endcase
    end

    // One read can be in flight; rd_port steers its data to the right port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_port  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rd_pend <= mem_ren;
            rd_port <= gnt[P_DBG];
            if (p0.rvalid) begin
                rdata0_q <= mem_dout;
            end
            if (p1.rvalid) begin
                rdata1_q <= mem_dout;
            end
        end
    end

    // A read still pending when reset is raised never reports valid.
    assign p0.rvalid = rd_pend && !rd_port && !reset;
    assign p1.rvalid = rd_pend && rd_port && !reset;
    assign p0.rdata  = p0.rvalid ? mem_dout : rdata0_q;
    assign p1.rdata  = p1.rvalid ? mem_dout : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 single-port memory.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DP = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          busy;
    logic          mem_wen;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] mem [DP];

    int checks = 0;
    int errors = 0;

    dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
    dmem_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .p0        (p0),
        .p1        (p1),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            p0.req = req; p0.we = we; p0.addr = addr; p0.wdata = wdata;
        end else begin
            p1.req = req; p1.we = we; p1.addr = addr; p1.wdata = wdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  clr_cycles;
        bit  gnt_seen;

        for (int a = 0; a < DP; a++) mem[a] = 32'hA5A5_0000 | a;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_gnt", {p1.gnt, p0.gnt}, 0);
        chk("rst_rvalid", {p1.rvalid, p0.rvalid}, 0);
        chk("rst_rdata", {p1.rdata, p0.rdata}, 0);
        chk("rst_strobes", {mem_wen, mem_ren}, 2'b10);

        // Clear walk after reset
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < DP; i++) begin
            @(negedge clk);
            chk("walk", {busy, mem_wen, mem_din, mem_addr}, {1'b1, 1'b1, 32'h0, AW'(i)});
        end
        @(negedge clk);
        chk("walk_done_busy", {busy, mem_wen, mem_ren}, 3'b000);

        // p0 write then read back
        tick();
        drive(0, 1'b1, 1'b1, 10'd15, 32'hCAFE_BABE);
        @(negedge clk);
        chk("p0_wr_gnt", {p1.gnt, p0.gnt}, 2'b01);
        chk("p0_wr_mem", {mem_wen, mem_ren, mem_addr, mem_din}, {1'b1, 1'b0, 10'd15, 32'hCAFE_BABE});
        tick();
        drive(0, 1'b1, 1'b0, 10'd15, '0);
        @(negedge clk);
        chk("p0_rd_gnt", p0.gnt, 1);
        chk("p0_rd_mem", {mem_wen, mem_ren, mem_addr, mem_din}, {1'b0, 1'b1, 10'd15, 32'h0});
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b1, 10'd16, 32'h0BAD_F00D);
        @(negedge clk);
        chk("p0_rd_rvalid", {p1.rvalid, p0.rvalid}, 2'b01);
        chk("p0_rd_rdata", p0.rdata, 32'hCAFE_BABE);
        chk("p1_wr_gnt", {p1.gnt, p0.gnt}, 2'b10);

        // Both ports read continuously: strict alternation starting with p0
        tick();
        drive(0, 1'b1, 1'b0, 10'd15, '0);
        drive(1, 1'b1, 1'b0, 10'd16, '0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("rr_gnt", {p1.gnt, p0.gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rvalid", {p1.rvalid, p0.rvalid},
                (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
            chk("rr_p0_rdata", p0.rdata, 32'hCAFE_BABE);
            chk("rr_p1_rdata", p1.rdata, (k >= 2) ? 32'h0BAD_F00D : 32'h0);
        end
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rr_last_gnt", {p1.gnt, p0.gnt}, 2'b00);
        chk("rr_last_rvalid", {p1.rvalid, p0.rvalid}, 2'b10);
        chk("rr_last_p1_rdata", p1.rdata, 32'h0BAD_F00D);

        // p1 write, then clear_req together with a p0 read
        tick();
        drive(1, 1'b1, 1'b1, 10'd100, 32'h1234_5678);
        @(negedge clk);
        chk("p1_wr100_gnt", {p1.gnt, p0.gnt, mem_wen, mem_addr}, {1'b1, 1'b0, 1'b1, 10'd100});
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b1, 1'b0, 10'd15, '0);
        clear_req = 1'b1;
        @(negedge clk);
        chk("clrreq_cycle", {busy, p0.gnt, mem_ren, mem_addr}, {1'b0, 1'b1, 1'b1, 10'd15});
        tick();
        clear_req = 1'b0;
        @(negedge clk);
        chk("clr_first", {busy, mem_wen, mem_addr, p0.gnt}, {1'b1, 1'b1, 10'd0, 1'b0});
        chk("clr_first_rvalid", {p1.rvalid, p0.rvalid}, 2'b01);
        chk("clr_first_rdata", p0.rdata, 32'hCAFE_BABE);

        // p0 keeps requesting through the walk; a clear_req mid-walk is ignored
        clr_cycles = 1;
        gnt_seen = 1'b0;
        for (int n = 0; n < 1100 && busy; n++) begin
            tick();
            clear_req = (n == 10);
            @(negedge clk);
            if (busy) begin
                clr_cycles++;
                gnt_seen = gnt_seen | p0.gnt;
            end
        end
        chk("clr_len", clr_cycles, DP);
        chk("clr_no_gnt", gnt_seen, 0);
        chk("serve_first_gnt", {busy, p0.gnt, mem_ren, mem_addr}, {1'b0, 1'b1, 1'b1, 10'd15});
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 10'd100, '0);
        @(negedge clk);
        chk("p1_rd100_gnt", {p1.gnt, p0.gnt}, 2'b10);
        chk("p0_cleared_rd", {p0.rvalid, p0.rdata}, {1'b1, 32'h0});
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("p1_cleared_rd", {p1.rvalid, p0.rvalid, p1.rdata}, {1'b1, 1'b0, 32'h0});

        // Reset right after a granted read cancels its rvalid
        tick();
        drive(0, 1'b1, 1'b0, 10'd16, '0);
        @(negedge clk);
        chk("pre_rst_gnt", p0.gnt, 1);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cancel_rvalid", {p1.rvalid, p0.rvalid}, 2'b00);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_walk0", {busy, mem_wen, mem_addr, p0.rvalid}, {1'b1, 1'b1, 10'd0, 1'b0});
        tick();
        @(negedge clk);
        chk("rst_walk1", {busy, mem_wen, mem_addr, p0.rvalid}, {1'b1, 1'b1, 10'd1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the single-port 1024×32 data memory. It shares the memory between two requesters: port 0 is the CPU MEM stage, port 1 is the program loader/debug port. It grants at most one access per cycle using round-robin priority and returns read data with a fixed one-cycle latency. It also owns memory initialisation: a hardware clear walk that writes zero to every word after reset or on request, so the memory itself needs no reset loop.

## Interface
Parameters:
- ADDR_W, 10, word-address width
- DATA_W, 32, data width
- DEPTH, 1024, words cleared by the clear walk; must equal 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- clear_req  in  1  one-cycle pulse; starts a clear walk
- busy  out  1  high while a clear walk is in progress
- p0_req  in  1  port 0 request; held until granted
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR_W  word address
- p0_wdata  in  DATA_W  write data
- p0_gnt  out  1  combinational grant; access happens this cycle
- p0_rvalid  out  1  registered; read data valid
- p0_rdata  out  DATA_W  read data
- p1_*  same set as p0_*, for port 1
- mem_wen, mem_ren  out  1  memory strobes
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data; valid one cycle after mem_ren

## Operation
- States: CLEAR and SERVE.
- reset enters CLEAR with clr_cnt=0 and rr_ptr=0 (port 0 favoured first).
- CLEAR
  - Each cycle: mem_wen=1, mem_addr=clr_cnt, mem_din=0, clr_cnt+1.
  - After the cycle with clr_cnt=DEPTH-1, go to SERVE.
  - No grants while in CLEAR. busy=1.
- SERVE arbitration
  - One requester: it is granted.
  - Both request: the port named by rr_ptr wins.
  - After any grant, rr_ptr points to the port that did not win.
  - With no grant, rr_ptr holds.
- Granted write: mem_wen=1 with the port's addr and wdata.
- Granted read: mem_ren=1. In the next cycle, pX_rvalid=1 and pX_rdata=mem_dout.
- pX_rdata holds its last value until the next read completes for that port.
- Requester rules:
  - addr, we and wdata must stay stable while req=1 and gnt=0.
  - Deasserting req before grant is allowed.
- clear_req in SERVE: that cycle's grant is still serviced, then CLEAR starts next cycle from clr_cnt=0.
- clear_req during CLEAR is ignored; the walk is not restarted.
- Unused mem outputs drive 0.

## Timing
- Reset values:
  - busy=1
  - pX_gnt=0, pX_rvalid=0, pX_rdata=0
  - mem_wen=1 (clear of address 0 begins the first cycle after reset)
  - mem_ren=0
- Clear duration: exactly DEPTH cycles. First grant possible at cycle DEPTH after reset deasserts.
- Read latency: 1 cycle, grant to rvalid.
- Back-to-back reads by the same port give one result per cycle if that port is the only requester.
- With both ports requesting continuously, grants strictly alternate.
- A read granted in the last SERVE cycle before CLEAR still gets its rvalid in the first CLEAR cycle.
- reset mid-read: the pending rvalid is cancelled and never asserted.
- reset mid-clear: the walk restarts at 0.
- clr_cnt is ADDR_W+1 bits wide, so DEPTH-1 does not wrap prematurely.
- Read/write to the same address in consecutive grants: the read returns the newly written data. Ordering is by grant order.

## Structure
- Package dmem_pkg holds:
  - ADDR_W/DATA_W/DEPTH defaults
  - state enum {ST_CLEAR, ST_SERVE}
  - port index constants P_CPU=0, P_DBG=1
- Sub-module rr_arb2: 2-way round-robin arbiter with pointer register. Inputs req[1:0] and enable; output gnt[1:0].
- The top level holds:
  - state and clear counter
  - mem mux
  - a 1-bit read-pending flag plus port-id register for rvalid steering

## Test plan
- Reset, then no requests:
  - busy high for exactly 1024 cycles
  - mem_wen=1 on every cycle, with mem_addr 0..1023 and mem_din=0
  - then busy=0
- After clear, p0 writes 0xCAFEBABE to address 15, then p0 reads address 15:
  - gnt on the request cycle
  - p0_rvalid=1 with p0_rdata=0xCAFEBABE one cycle later
- p0 and p1 both hold read requests for 4 cycles:
  - grants go p0, p1, p0, p1
  - each rvalid lands on the granted port one cycle later
  - no cross-delivery
- p1 writes 0x12345678 to address 100, then clear_req pulses, then p1 reads address 100 after busy falls:
  - read returns 0x00000000
- During CLEAR, p0_req=1:
  - p0_gnt stays 0 for the whole walk
  - granted in the first SERVE cycle
- p0 read granted, then reset asserted the next cycle:
  - p0_rvalid never asserts
  - busy=1 and the walk restarts at address 0
